// File: rtl/hline_pkg.sv
// Shared types and constants for the horizontal-line move controller.
// State codes are visible on the debug LEDs.
package hline_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN_INC = 3'd2,
        S_RUN_DEC = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    localparam logic [15:0] Y_MIN      = 16'd18;
    localparam logic [15:0] Y_MAX      = 16'd630;
    localparam logic [15:0] INIT_Y_DEF = 16'd18;

    function automatic logic is_run(input state_t s);
        return (s == S_RUN_INC) || (s == S_RUN_DEC);
    endfunction

endpackage

// File: rtl/hline_tick_div.sv
// Frame divider with settle guard.
// Emits one qualifying-tick strobe every STEP_FRAMES accepted ticks.
module hline_tick_div #(
    parameter int STEP_FRAMES = 2,
    parameter int DW_WIDTH    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic en,
    input  logic clr,
    input  logic pulse,
    output logic qual
);

    localparam logic [DW_WIDTH-1:0] LAST = DW_WIDTH'(STEP_FRAMES - 1);

    logic [DW_WIDTH-1:0] div;
    logic                settle;
    logic                adv;

    // Counter flags are stale while a pulse is in flight and just after it.
    assign adv  = en & frame_tick & ~clr & ~pulse & ~settle;
    assign qual = adv & (div == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            settle <= 1'b0;
        end else begin
            settle <= pulse;
            if (clr)
                div <= '0;
            else if (adv)
                div <= qual ? '0 : div + DW_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hline_move_ctrl.sv
// Sequencer turning frame ticks into inc/dec/load pulses
// for the horizontal-line position counter.
module hline_move_ctrl
    import hline_pkg::*;
#(
    parameter int          STEP_FRAMES = 2,
    parameter logic [15:0] INIT_Y      = INIT_Y_DEF,
    parameter int          DW_WIDTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        stop,
    input  logic        load_req,
    input  logic [15:0] load_val,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        at_max,
    input  logic        at_min,
    output logic        inc,
    output logic        dec,
    output logic        ld,
    output logic [15:0] d,
    output logic        dir,
    output logic        running,
    output logic [2:0]  state
);

    state_t      st, st_n;
    logic        dir_n, inc_n, dec_n, ld_n;
    logic [15:0] d_n;
    logic        qual, busy, div_en, load_go;

    // Blocking new pulses while one is high keeps them one cycle wide.
    assign busy    = inc | dec | ld;
    assign load_go = load_req & ~busy;
    assign div_en  = is_run(st) | (st == S_PAUSE);
    assign running = is_run(st);
    assign state   = st;

    hline_tick_div #(
        .STEP_FRAMES (STEP_FRAMES),
        .DW_WIDTH    (DW_WIDTH)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .en         (div_en),
        .clr        (load_go),
        .pulse      (busy),
        .qual       (qual)
    );

    always_comb begin
        st_n  = st;
        dir_n = dir;
        inc_n = 1'b0;
        dec_n = 1'b0;
        ld_n  = 1'b0;
        d_n   = d;
        if (load_go) begin
            d_n  = load_val;
            ld_n = 1'b1;
            st_n = S_PAUSE;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (start && !busy) begin
                        d_n   = INIT_Y;
                        ld_n  = 1'b1;
                        dir_n = 1'b1;
                        st_n  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    dir_n = 1'b1;
                    st_n  = S_RUN_INC;
                end
                S_RUN_INC: begin
                    if (stop) begin
                        st_n = S_PAUSE;
                    end else if (qual) begin
                        if (at_max) begin
                            dir_n = 1'b0;
                            dec_n = 1'b1;
                            st_n  = S_RUN_DEC;
                        end else begin
                            inc_n = 1'b1;
                        end
                    end
                end
                S_RUN_DEC: begin
                    if (stop) begin
                        st_n = S_PAUSE;
                    end else if (qual) begin
                        if (at_min) begin
                            dir_n = 1'b1;
                            inc_n = 1'b1;
                            st_n  = S_RUN_INC;
                        end else begin
                            dec_n = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start && !busy) begin
                        d_n   = INIT_Y;
                        ld_n  = 1'b1;
                        dir_n = 1'b1;
                        st_n  = S_LOAD;
                    end else if (qual) begin
                        unique case (1'b1)
                            (btn_inc & ~btn_dec & ~at_max): inc_n = 1'b1;
                            (btn_dec & ~btn_inc & ~at_min): dec_n = 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: st_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= S_IDLE;
            dir <= 1'b1;
            inc <= 1'b0;
            dec <= 1'b0;
            ld  <= 1'b0;
            d   <= '0;
        end else begin
            st  <= st_n;
            dir <= dir_n;
            inc <= inc_n;
            dec <= dec_n;
            ld  <= ld_n;
            d   <= d_n;
        end
    end

endmodule

// File: tb/tb_hline_move_ctrl.sv
// Directed bench for hline_move_ctrl driving a behavioural
// line counter with limits 18 and 630.
module tb_hline_move_ctrl;
    import hline_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] load_val = '0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic        at_max, at_min;
    logic        inc, dec, ld, dir, running;
    logic [15:0] d;
    logic [2:0]  state;

    logic [15:0] y = '0;
    logic        pre_en = 1'b0;
    logic [15:0] pre_val = '0;

    int checks = 0;
    int errors = 0;
    int inc_cnt = 0;
    int dec_cnt = 0;
    int viol = 0;
    logic prev_p = 1'b0;
    logic prev_ld = 1'b0;
    logic [15:0] prev_d = '0;

    always #5 clk = ~clk;

    hline_move_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .start(start), .stop(stop), .load_req(load_req),
        .load_val(load_val), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .at_max(at_max), .at_min(at_min), .inc(inc), .dec(dec),
        .ld(ld), .d(d), .dir(dir), .running(running), .state(state)
    );

    assign at_max = (y == Y_MAX);
    assign at_min = (y == Y_MIN);

    // Line counter model; pre_en lets the bench place Y directly.
    always @(posedge clk) begin
        if (pre_en)   y <= pre_val;
        else if (ld)  y <= d;
        else if (inc) y <= y + 16'd1;
        else if (dec) y <= y - 16'd1;
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (inc) inc_cnt++;
            if (dec) dec_cnt++;
            if (inc && at_max) viol++;
            if (dec && at_min) viol++;
            if ((32'(inc) + 32'(dec) + 32'(ld)) > 1) viol++;
            if (prev_p && (inc || dec || ld)) viol++;
            if (d != prev_d && !(ld && !prev_ld)) viol++;
        end
        prev_p  <= inc | dec | ld;
        prev_ld <= ld;
        prev_d  <= d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(output logic pi, output logic pd);
        repeat (2) step();
        frame_tick = 1'b1;
        step();
        pi = inc;
        pd = dec;
        frame_tick = 1'b0;
        repeat (2) step();
    endtask

    task automatic preset(input logic [15:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        step();
        pre_en  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if (state !== 3'd0 || inc !== 0 || dec !== 0 || ld !== 0) begin
            errors++;
            $display("FAIL reset_ctl: state=%0d inc=%b dec=%b ld=%b, want 0 0 0 0",
                     state, inc, dec, ld);
        end
        checks++;
        if (dir !== 1'b1 || d !== 16'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_dir_d: dir=%b d=%0d run=%b, want 1 0 0", dir, d, running);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_start();
        logic pi, pd;
        int ic;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (ld !== 1'b1 || d !== 16'd18 || state !== 3'd1) begin
            errors++;
            $display("FAIL start_load: ld=%b d=%0d state=%0d, want 1 18 1", ld, d, state);
        end
        step();
        checks++;
        if (ld !== 1'b0 || state !== 3'd2 || y !== 16'd18 || dir !== 1'b1) begin
            errors++;
            $display("FAIL start_run: ld=%b state=%0d y=%0d dir=%b, want 0 2 18 1",
                     ld, state, y, dir);
        end
        ic = inc_cnt;
        for (int i = 0; i < 10; i++) frame(pi, pd);
        checks++;
        if (inc_cnt - ic !== 5 || y !== 16'd23) begin
            errors++;
            $display("FAIL start_incs: pulses=%0d y=%0d, want 5 23", inc_cnt - ic, y);
        end
    endtask

    task automatic test_bounce();
        logic pi, pd;
        preset(16'd629);
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (pi !== 1'b1 || y !== 16'd630) begin
            errors++;
            $display("FAIL max_reach: inc=%b y=%0d, want 1 630", pi, y);
        end
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (pd !== 1'b1 || pi !== 1'b0 || dir !== 1'b0 || state !== 3'd3 || y !== 16'd629) begin
            errors++;
            $display("FAIL max_bounce: dec=%b inc=%b dir=%b state=%0d y=%0d, want 1 0 0 3 629",
                     pd, pi, dir, state, y);
        end
        preset(16'd19);
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (pd !== 1'b1 || y !== 16'd18) begin
            errors++;
            $display("FAIL min_reach: dec=%b y=%0d, want 1 18", pd, y);
        end
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (pi !== 1'b1 || dir !== 1'b1 || state !== 3'd2 || y !== 16'd19) begin
            errors++;
            $display("FAIL min_bounce: inc=%b dir=%b state=%0d y=%0d, want 1 1 2 19",
                     pi, dir, state, y);
        end
    endtask

    task automatic test_load_pause();
        logic pi, pd;
        int ic, dc;
        preset(16'd630);
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (state !== 3'd3 || y !== 16'd629) begin
            errors++;
            $display("FAIL pre_load: state=%0d y=%0d, want 3 629", state, y);
        end
        load_val = 16'd300;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        checks++;
        if (ld !== 1'b1 || d !== 16'd300 || state !== 3'd4) begin
            errors++;
            $display("FAIL load: ld=%b d=%0d state=%0d, want 1 300 4", ld, d, state);
        end
        step();
        btn_inc = 1'b1;
        for (int i = 0; i < 6; i++) frame(pi, pd);
        checks++;
        if (y !== 16'd303) begin
            errors++;
            $display("FAIL btn_inc: y=%0d, want 303", y);
        end
        btn_dec = 1'b1;
        ic = inc_cnt;
        dc = dec_cnt;
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (inc_cnt != ic || dec_cnt != dc || y !== 16'd303) begin
            errors++;
            $display("FAIL btn_both: pulses=%0d y=%0d, want 0 303",
                     inc_cnt - ic + dec_cnt - dc, y);
        end
        btn_inc = 1'b0;
        preset(16'd20);
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (y !== 16'd19) begin
            errors++;
            $display("FAIL btn_dec: y=%0d, want 19", y);
        end
        preset(16'd18);
        dc = dec_cnt;
        frame(pi, pd);
        frame(pi, pd);
        checks++;
        if (dec_cnt != dc || y !== 16'd18) begin
            errors++;
            $display("FAIL btn_dec_min: pulses=%0d y=%0d, want 0 18", dec_cnt - dc, y);
        end
        btn_dec = 1'b0;
    endtask

    task automatic test_stop();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (state !== 3'd2 || ld !== 1'b0 || y !== 16'd18) begin
            errors++;
            $display("FAIL start_in_run: state=%0d ld=%b y=%0d, want 2 0 18", state, ld, y);
        end
        stop = 1'b1;
        step();
        checks++;
        if (state !== 3'd4 || running !== 1'b0 || dir !== 1'b1) begin
            errors++;
            $display("FAIL stop: state=%0d run=%b dir=%b, want 4 0 1", state, running, dir);
        end
        step();
        stop = 1'b0;
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL stop_pause: state=%0d, want 4", state);
        end
    endtask

    task automatic test_simultaneous();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        load_val = 16'd500;
        load_req = 1'b1;
        stop = 1'b1;
        start = 1'b1;
        step();
        load_req = 1'b0;
        stop = 1'b0;
        start = 1'b0;
        checks++;
        if (state !== 3'd4 || ld !== 1'b1 || d !== 16'd500) begin
            errors++;
            $display("FAIL load_wins: state=%0d ld=%b d=%0d, want 4 1 500", state, ld, d);
        end
        step();
        checks++;
        if (y !== 16'd500) begin
            errors++;
            $display("FAIL load_wins_y: y=%0d, want 500", y);
        end
    endtask

    task automatic test_settle();
        logic pi, pd, p0;
        int ic;
        btn_inc = 1'b1;
        frame(pi, pd);
        checks++;
        if (pi !== 1'b0) begin
            errors++;
            $display("FAIL settle_pre: inc=%b, want 0", pi);
        end
        ic = inc_cnt;
        repeat (2) step();
        frame_tick = 1'b1;
        step();
        p0 = inc;
        step();
        step();
        frame_tick = 1'b0;
        repeat (2) step();
        checks++;
        if (p0 !== 1'b1 || inc_cnt - ic !== 1) begin
            errors++;
            $display("FAIL settle_burst: first=%b pulses=%0d, want 1 1", p0, inc_cnt - ic);
        end
        frame(pi, pd);
        checks++;
        if (pi !== 1'b0) begin
            errors++;
            $display("FAIL settle_div_held: inc=%b, want 0", pi);
        end
        frame(pi, pd);
        checks++;
        if (pi !== 1'b1 || y !== 16'd502) begin
            errors++;
            $display("FAIL settle_next: inc=%b y=%0d, want 1 502", pi, y);
        end
        btn_inc = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        load_val = 16'd77;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        checks++;
        if (ld !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: ld=%b, want 1", ld);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ld !== 1'b0 || state !== 3'd0 || d !== 16'd0) begin
            errors++;
            $display("FAIL rst_async: ld=%b state=%0d d=%0d, want 0 0 0", ld, state, d);
        end
        step();
        checks++;
        if (y !== 16'd502) begin
            errors++;
            $display("FAIL rst_no_load: y=%0d, want 502", y);
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_load_pause();
        test_stop();
        test_simultaneous();
        test_settle();
        test_reset_mid_pulse();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL invariants: violations=%0d, want 0", viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
